// File: rtl/pc_seq_pkg.sv
// Shared types and constants for the PC sequencer: state encoding, widths,
// reset PC default and the redirect payload carried from the datapath.
package pc_seq_pkg;

    localparam int unsigned ADDR_W       = 32;
    localparam int unsigned INSTR_W      = 32;
    localparam int unsigned JTGT_W       = 26;
    localparam int unsigned CNT_W        = 32;
    localparam int unsigned TIMEOUT_DFLT = 16;

    localparam logic [ADDR_W-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_ISSUE  = 3'd2,
        ST_HALTED = 3'd3,
        ST_FAULT  = 3'd4
    } state_e;

    typedef struct packed {
        logic              jump;
        logic              pc_src;
        logic [ADDR_W-1:0] branch_offset;
        logic [JTGT_W-1:0] jump_target;
    } redirect_t;

endpackage

// File: rtl/pc_next_calc.sv
// Combinational next-PC selection: jump beats branch, branch beats fall-through.
module pc_next_calc
    import pc_seq_pkg::*;
(
    input  logic [ADDR_W-1:0] pc,
    input  redirect_t         redirect,
    output logic [ADDR_W-1:0] next_pc_c
);

    logic [ADDR_W-1:0] pc_plus4;
    logic [ADDR_W-1:0] branch_tgt;

    always_comb begin
        pc_plus4   = pc + ADDR_W'(4);
        // Word offset scaled to bytes; bits shifted past the top are dropped.
        branch_tgt = pc_plus4 + (redirect.branch_offset << 2);
        next_pc_c  = pc_plus4;
        if (redirect.jump) begin
            next_pc_c = {pc_plus4[ADDR_W-1:ADDR_W-4], redirect.jump_target, 2'b00};
        end else if (redirect.pc_src) begin
            next_pc_c = branch_tgt;
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// Fetch/issue sequencer: fetches at pc, hands the word to the datapath and
// advances pc on exec_done; fetch timeout and halt are terminal until reset.
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter logic [ADDR_W-1:0] RESET_PC      = RESET_PC_DEFAULT,
    parameter int unsigned       FETCH_TIMEOUT = TIMEOUT_DFLT
) (
    input  logic               clk,
    input  logic               rst_n,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic               imem_ack,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic               instr_valid,
    output logic [INSTR_W-1:0] instr,
    output logic [ADDR_W-1:0]  instr_pc,
    input  logic               exec_done,
    input  logic               pc_src,
    input  logic [ADDR_W-1:0]  branch_offset,
    input  logic               jump,
    input  logic [JTGT_W-1:0]  jump_target,
    input  logic               halt,
    output logic [ADDR_W-1:0]  pc,
    output logic [CNT_W-1:0]   instret,
    output logic               halted,
    output logic               fault
);

    localparam int unsigned TO_W = $clog2(FETCH_TIMEOUT + 1);

    state_e             state_q, state_d;
    logic [ADDR_W-1:0]  pc_q, pc_d;
    logic [INSTR_W-1:0] instr_q, instr_d;
    logic [ADDR_W-1:0]  instr_pc_q, instr_pc_d;
    logic [CNT_W-1:0]   instret_q, instret_d;
    logic [TO_W-1:0]    to_cnt_q, to_cnt_d;
    logic               imem_req_q, imem_req_d;
    logic               instr_valid_q, instr_valid_d;
    logic               halted_q, halted_d;
    logic               fault_q, fault_d;

    redirect_t          redirect;
    logic [ADDR_W-1:0]  next_pc_c;

    assign redirect.jump          = jump;
    assign redirect.pc_src        = pc_src;
    assign redirect.branch_offset = branch_offset;
    assign redirect.jump_target   = jump_target;

    pc_next_calc u_pc_next_calc (
        .pc        (pc_q),
        .redirect  (redirect),
        .next_pc_c (next_pc_c)
    );

    // Next-state, datapath capture and registered strobe decode.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        instr_d    = instr_q;
        instr_pc_d = instr_pc_q;
        instret_d  = instret_q;
        to_cnt_d   = to_cnt_q;

        unique case (state_q)
            ST_IDLE: begin
                state_d  = ST_FETCH;
                to_cnt_d = '0;
            end
            ST_FETCH: begin
                if (imem_ack) begin
                    instr_d    = imem_rdata;
                    instr_pc_d = pc_q;
                    state_d    = ST_ISSUE;
                end else begin
                    to_cnt_d = to_cnt_q + TO_W'(1);
                    if (to_cnt_d == TO_W'(FETCH_TIMEOUT)) begin
                        state_d = ST_FAULT;
                    end
                end
            end
            ST_ISSUE: begin
                if (exec_done) begin
                    pc_d      = next_pc_c;
                    instret_d = instret_q + CNT_W'(1);
                    to_cnt_d  = '0;
                    state_d   = halt ? ST_HALTED : ST_FETCH;
                end
            end
            ST_HALTED, ST_FAULT: begin
                state_d = state_q;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        imem_req_d    = (state_d == ST_FETCH);
        instr_valid_d = (state_d == ST_ISSUE);
        halted_d      = (state_d == ST_HALTED);
        fault_d       = (state_d == ST_FAULT);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            pc_q          <= RESET_PC;
            instr_q       <= '0;
            instr_pc_q    <= '0;
            instret_q     <= '0;
            to_cnt_q      <= '0;
            imem_req_q    <= 1'b0;
            instr_valid_q <= 1'b0;
            halted_q      <= 1'b0;
            fault_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            instr_q       <= instr_d;
            instr_pc_q    <= instr_pc_d;
            instret_q     <= instret_d;
            to_cnt_q      <= to_cnt_d;
            imem_req_q    <= imem_req_d;
            instr_valid_q <= instr_valid_d;
            halted_q      <= halted_d;
            fault_q       <= fault_d;
        end
    end

    assign imem_req    = imem_req_q;
    assign imem_addr   = pc_q;
    assign instr_valid = instr_valid_q;
    assign instr       = instr_q;
    assign instr_pc    = instr_pc_q;
    assign pc          = pc_q;
    assign instret     = instret_q;
    assign halted      = halted_q;
    assign fault       = fault_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: fetches push expected issue records,
// a monitor pops and compares them each time instr_valid rises.
module tb_pc_sequencer;

    logic        clk;
    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        exec_done;
    logic        pc_src;
    logic [31:0] branch_offset;
    logic        jump;
    logic [25:0] jump_target;
    logic        halt;
    logic [31:0] pc;
    logic [31:0] instret;
    logic        halted;
    logic        fault;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] instret;
    } exp_t;

    exp_t sb_q[$];

    pc_sequencer #(
        .RESET_PC      (32'h0000_0000),
        .FETCH_TIMEOUT (16)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_ack      (imem_ack),
        .imem_rdata    (imem_rdata),
        .instr_valid   (instr_valid),
        .instr         (instr),
        .instr_pc      (instr_pc),
        .exec_done     (exec_done),
        .pc_src        (pc_src),
        .branch_offset (branch_offset),
        .jump          (jump),
        .jump_target   (jump_target),
        .halt          (halt),
        .pc            (pc),
        .instret       (instret),
        .halted        (halted),
        .fault         (fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        total++;
        bad++;
        $display("FAIL %s: bound expired", name);
    endtask

    // Monitor: every new issue must match the oldest outstanding fetch.
    initial begin
        logic prev_valid;
        exp_t e;
        prev_valid = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            if (instr_valid && !prev_valid) begin
                if (sb_q.size() == 0) begin
                    fail_now("issue_unexpected");
                end else begin
                    e = sb_q.pop_front();
                    check32("issue_instr", instr, e.instr);
                    check32("issue_instr_pc", instr_pc, e.pc);
                    check32("issue_instret", instret, e.instret);
                    check32("issue_req_low", 32'(imem_req), 32'd0);
                end
            end
            prev_valid = instr_valid;
        end
    end

    task automatic wait_req(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (imem_req) begin
                ok = 1'b1;
                break;
            end
            @(posedge clk);
            #1;
        end
        if (!ok) fail_now("wait_imem_req");
    endtask

    task automatic fetch(input logic [31:0] rdata, input int delay,
                         input logic [31:0] exp_pc, input logic [31:0] exp_ir);
        bit ok;
        wait_req(ok);
        if (!ok) return;
        check32("fetch_addr", imem_addr, exp_pc);
        sb_q.push_back('{instr: rdata, pc: exp_pc, instret: exp_ir});
        repeat (delay) begin
            @(posedge clk);
            #1;
        end
        imem_ack   = 1'b1;
        imem_rdata = rdata;
        @(posedge clk);
        #1;
        imem_ack   = 1'b0;
        imem_rdata = 32'hA5A5_5A5A;
    endtask

    task automatic execute(input logic j, input logic src, input logic [31:0] off,
                           input logic [25:0] tgt, input logic hlt,
                           input logic [31:0] exp_pc, input logic [31:0] exp_ir);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (instr_valid) begin
                ok = 1'b1;
                break;
            end
            @(posedge clk);
            #1;
        end
        if (!ok) begin
            fail_now("wait_instr_valid");
            return;
        end
        jump          = j;
        pc_src        = src;
        branch_offset = off;
        jump_target   = tgt;
        halt          = hlt;
        exec_done     = 1'b1;
        @(posedge clk);
        #1;
        exec_done     = 1'b0;
        jump          = 1'b0;
        pc_src        = 1'b0;
        halt          = 1'b0;
        check32("exec_pc", pc, exp_pc);
        check32("exec_instret", instret, exp_ir);
    endtask

    task automatic check_reset_state(input string tag);
        check32({tag, "_pc"}, pc, 32'h0);
        check32({tag, "_instr"}, instr, 32'h0);
        check32({tag, "_instr_pc"}, instr_pc, 32'h0);
        check32({tag, "_instret"}, instret, 32'h0);
        check32({tag, "_flags"}, {28'h0, imem_req, instr_valid, halted, fault}, 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int req_cycles;
        rst_n         = 1'b0;
        imem_ack      = 1'b0;
        imem_rdata    = 32'h0;
        exec_done     = 1'b0;
        pc_src        = 1'b0;
        branch_offset = 32'h0;
        jump          = 1'b0;
        jump_target   = 26'h0;
        halt          = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        check_reset_state("reset");
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check32("idle_then_fetch_req", 32'(imem_req), 32'd1);

        // Straight-line, jump, branch, far branch, jump-over-branch, wrap.
        fetch(32'h2001_0005, 2, 32'h0000_0000, 32'd0);
        execute(1'b0, 1'b0, 32'h0, 26'h0, 1'b0, 32'h0000_0004, 32'd1);
        fetch(32'h0800_0040, 0, 32'h0000_0004, 32'd1);
        execute(1'b1, 1'b0, 32'h0, 26'h000_0040, 1'b0, 32'h0000_0100, 32'd2);
        fetch(32'h1000_FFFF, 1, 32'h0000_0100, 32'd2);
        execute(1'b0, 1'b1, 32'hFFFF_FFFC, 26'h0, 1'b0, 32'h0000_00F4, 32'd3);
        fetch(32'h1000_0001, 3, 32'h0000_00F4, 32'd3);
        execute(1'b0, 1'b1, 32'h03FF_FFC2, 26'h0, 1'b0, 32'h1000_0000, 32'd4);
        fetch(32'h0C00_0040, 0, 32'h1000_0000, 32'd4);
        execute(1'b1, 1'b1, 32'h0000_0005, 26'h000_0040, 1'b0, 32'h1000_0100, 32'd5);
        fetch(32'h1400_0002, 0, 32'h1000_0100, 32'd5);
        execute(1'b0, 1'b1, 32'h3BFF_FFBE, 26'h0, 1'b0, 32'hFFFF_FFFC, 32'd6);
        fetch(32'h0000_0000, 0, 32'hFFFF_FFFC, 32'd6);
        execute(1'b0, 1'b0, 32'h0, 26'h0, 1'b0, 32'h0000_0000, 32'd7);
        fetch(32'h1000_0003, 0, 32'h0000_0000, 32'd7);
        execute(1'b0, 1'b1, 32'h4000_0001, 26'h0, 1'b0, 32'h0000_0008, 32'd8);
        fetch(32'hFC00_0000, 0, 32'h0000_0008, 32'd8);
        execute(1'b0, 1'b0, 32'h0, 26'h0, 1'b1, 32'h0000_000C, 32'd9);

        // Halted is terminal: stray ack/exec_done must not move anything.
        check32("halted_flag", {30'h0, halted, fault}, 32'h2);
        imem_ack  = 1'b1;
        exec_done = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        imem_ack  = 1'b0;
        exec_done = 1'b0;
        check32("halted_pc", pc, 32'h0000_000C);
        check32("halted_instret", instret, 32'd9);
        check32("halted_instr", instr, 32'hFC00_0000);
        check32("halted_strobes", {30'h0, imem_req, instr_valid}, 32'h0);
        check32("halted_flag_held", {30'h0, halted, fault}, 32'h2);

        // Async reset out of HALTED, then a late ack while IDLE.
        rst_n = 1'b0;
        #1;
        check_reset_state("reset_halted");
        @(posedge clk);
        #1;
        rst_n    = 1'b1;
        imem_ack = 1'b1;
        @(posedge clk);
        #1;
        imem_ack = 1'b0;
        check32("late_ack_ignored", {30'h0, imem_req, instr_valid}, 32'h2);

        // Minimum fetch latency, then reset in the middle of ISSUE.
        fetch(32'h1111_2222, 0, 32'h0000_0000, 32'd0);
        execute(1'b0, 1'b0, 32'h0, 26'h0, 1'b0, 32'h0000_0004, 32'd1);
        fetch(32'h3333_4444, 0, 32'h0000_0004, 32'd1);
        #3;
        check32("mid_issue_valid", 32'(instr_valid), 32'd1);
        rst_n = 1'b0;
        #1;
        check_reset_state("reset_mid_issue");
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Fetch timeout: exactly 16 FETCH cycles with req before FAULT.
        req_cycles = 0;
        @(posedge clk);
        #1;
        for (int i = 0; i < 40; i++) begin
            if (fault) break;
            if (imem_req) req_cycles++;
            @(posedge clk);
            #1;
        end
        check32("timeout_req_cycles", 32'(req_cycles), 32'd16);
        check32("fault_flag", {30'h0, halted, fault}, 32'h1);
        check32("fault_req_low", 32'(imem_req), 32'd0);
        check32("fault_pc", pc, 32'h0000_0000);
        imem_ack   = 1'b1;
        imem_rdata = 32'hDEAD_BEEF;
        repeat (4) @(posedge clk);
        #1;
        imem_ack   = 1'b0;
        check32("fault_ack_ignored_instr", instr, 32'h0);
        check32("fault_ack_ignored_strobes", {30'h0, imem_req, instr_valid}, 32'h0);
        check32("fault_sticky", 32'(fault), 32'd1);

        repeat (3) @(posedge clk);
        check32("scoreboard_drained", 32'(sb_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
